dice_tile_cfg_loader: RTL and testbench
=======================================

# dice_tile_cfg_loader

Per-tile configuration loader that sits directly upstream of a DICE tile's static `tile_cfg` input. It accepts 32-bit configuration words from a broadcast config stream and assembles this tile's 156-bit configuration in a shadow register. On a global `cfg_apply` pulse it atomically copies the shadow into the active `tile_cfg`, so every tile in the array switches configuration on the same cycle.

## Interface
Parameters:
- `TILE_ID`, default 0: this tile's address, matched against packet headers.
- `ID_W`, default 8: width of the tile-id field in the header.
- `CFG_W`, default 156: active config width; `WORDS = ceil(CFG_W/32)` (5), `PAD = WORDS*32 - CFG_W` (4).

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  config word valid.
- `in_data`  in  32  config word.
- `in_ready`  out  1  word accepted when `in_valid && in_ready`.
- `cfg_apply`  in  1  global commit pulse.
- `tile_cfg`  out  CFG_W  active configuration, to the tile.
- `cfg_loaded`  out  1  `tile_cfg` has been written at least once since reset.
- `busy`  out  1  state is not IDLE.
- `err`  out  1  sticky protocol error.

## Operation
- Packet format: one header word, then `WORDS` payload words.
  - Header bits [31:24] must equal `CFG_MAGIC` (8'hC5). Bits [ID_W-1:0] carry the destination tile id.
  - Payload word k (0..WORDS-1) loads `shadow[32k+31:32k]`. The last word loads only its low `32-PAD` bits. Its upper `PAD` bits must be zero.
- FSM states:
  - **IDLE**: accept a word.
    - Bad magic: drop the word, set `err`, stay in IDLE.
    - Good magic, id == TILE_ID: clear the word counter, go to LOAD.
    - Good magic, other id: clear the word counter, go to SKIP.
  - **LOAD**: each accepted word is written into the shadow at slot `wcnt`, then `wcnt++`. After word `WORDS-1` is accepted, go to ARM. Nonzero pad bits set `err`, but the word is still loaded.
  - **SKIP**: accept and discard `WORDS` words, then go to IDLE.
  - **ARM**: `in_ready`=0. When `cfg_apply`=1: `tile_cfg <= shadow`, `cfg_loaded <= 1`, go to IDLE.
- `in_ready` = 1 in IDLE, LOAD and SKIP; 0 in ARM.
- `cfg_apply` in any state other than ARM is ignored and does not change `tile_cfg`.
- `err` clears only on `rst`.
- `busy` = 1 in LOAD, SKIP and ARM.
- Reset values: `tile_cfg`=0, `cfg_loaded`=0, `err`=0, `busy`=0, state=IDLE, `wcnt`=0, shadow=0.

## Timing
- `in_ready` is a combinational decode of the registered state only. It never depends on `in_valid` or `in_data`.
- `tile_cfg` updates on the clock edge that samples `cfg_apply` in ARM, so it is visible one cycle after the pulse.
- Minimum time from header to ARM is WORDS+1 accepted cycles (6). A back-to-back packet header can be accepted on the cycle after leaving SKIP or ARM.
- Gaps (`in_valid`=0) are allowed anywhere. State and counter hold during gaps.
- Final payload word and `cfg_apply` in the same cycle: the word is loaded and state goes to ARM. The apply is ignored because the FSM was not yet armed.
- A `cfg_apply` lasting several cycles in ARM commits once. In the following cycle the FSM is in IDLE, so the remaining cycles are ignored.
- `rst` asserted mid-packet: the partial shadow is discarded, all outputs return to their reset values on that edge, and the next accepted word is treated as a header.
- `wcnt` is `$clog2(WORDS+1)` bits wide and never wraps past `WORDS-1`.

## Structure
- Package `dice_cfg_pkg` holds:
  - `CFG_MAGIC` = 8'hC5
  - `TILE_CFG_W` = 156
  - `CFG_WORD_W` = 32
  - the `cfg_ld_state_e` enum {IDLE, LOAD, SKIP, ARM}
- Single flat module; no sub-module is warranted. The shadow register, active register, counter and FSM all live in `dice_tile_cfg_loader`.

## Test plan
- **Basic load**: TILE_ID=3. Send header 32'hC500_0003, then words 32'h1111_1111, 2222_2222, 3333_3333, 4444_4444, 0AAA_AAAA. Pulse apply. Required: `tile_cfg` = {28'hAAA_AAAA, 32'h4444_4444, ..., 32'h1111_1111} one cycle later, `cfg_loaded`=1, `err`=0.
- **Foreign packet**: send header 32'hC500_0007 plus 5 words, then apply. Required: `tile_cfg` stays 0, `busy` drops after the 5th word, `in_ready` stays 1 throughout.
- **Errors**:
  - Header 32'h1200_0003: word dropped, `err`=1, FSM stays IDLE.
  - Valid packet whose last word is 32'hF000_0001: loaded, `err`=1, `tile_cfg[155:128]`=28'h1 after apply.
- **Backpressure in ARM**: while ARM, present the next header for 4 cycles. Required: `in_ready`=0 until apply. The header is accepted on the cycle after `tile_cfg` updates.
- **Simultaneous events**: last payload word and `cfg_apply` in the same cycle. Required: `tile_cfg` unchanged and state ARM. A second apply then commits.
- **Reset mid-load**: assert `rst` after 2 payload words, then send a full valid packet and apply. Required: all outputs are 0 after reset, and the new payload appears intact.

Source files
------------

// File: rtl/dice_cfg_pkg.sv
// Shared constants, state encoding and header helper for the DICE tile
// configuration loader.
package dice_cfg_pkg;

  localparam logic [7:0] CFG_MAGIC  = 8'hC5;
  localparam int         TILE_CFG_W = 156;
  localparam int         CFG_WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SKIP,
    ARM
  } cfg_ld_state_e;

  function automatic logic hdr_magic_ok(input logic [CFG_WORD_W-1:0] w);
    return (w[31:24] == CFG_MAGIC);
  endfunction

endpackage

// File: rtl/dice_tile_cfg_loader.sv
// Assembles one tile's configuration from a broadcast word stream into a
// shadow register and commits it to tile_cfg on a global apply pulse.
module dice_tile_cfg_loader
  import dice_cfg_pkg::*;
#(
  parameter int TILE_ID = 0,
  parameter int ID_W    = 8,
  parameter int CFG_W   = TILE_CFG_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [CFG_WORD_W-1:0] in_data,
  output logic                  in_ready,
  input  logic                  cfg_apply,
  output logic [CFG_W-1:0]      tile_cfg,
  output logic                  cfg_loaded,
  output logic                  busy,
  output logic                  err
);

  localparam int WORDS = (CFG_W + CFG_WORD_W - 1) / CFG_WORD_W;
  localparam int PAD   = WORDS * CFG_WORD_W - CFG_W;
  localparam int CNT_W = $clog2(WORDS + 1);

  localparam logic [CFG_WORD_W-1:0] PAD_MASK  = ~({CFG_WORD_W{1'b1}} >> PAD);
  localparam logic [CNT_W-1:0]      LAST_WORD = CNT_W'(WORDS - 1);
  localparam logic [ID_W-1:0]       MY_ID     = ID_W'(TILE_ID);

  cfg_ld_state_e    state_q, state_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic [CFG_W-1:0] shadow_q, shadow_d;
  logic [CFG_W-1:0] tile_cfg_q, tile_cfg_d;
  logic             cfg_loaded_q, cfg_loaded_d;
  logic             err_q, err_d;
  logic             accept;
  logic             last_word;

  assign in_ready   = (state_q != ARM);
  assign busy       = (state_q != IDLE);
  assign tile_cfg   = tile_cfg_q;
  assign cfg_loaded = cfg_loaded_q;
  assign err        = err_q;

  assign accept    = in_valid && in_ready;
  assign last_word = (wcnt_q == LAST_WORD);

  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    shadow_d     = shadow_q;
    tile_cfg_d   = tile_cfg_q;
    cfg_loaded_d = cfg_loaded_q;
    err_d        = err_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!hdr_magic_ok(in_data)) begin
            err_d = 1'b1;
          end else begin
            wcnt_d  = '0;
            state_d = (in_data[ID_W-1:0] == MY_ID) ? LOAD : SKIP;
          end
        end
      end

      LOAD: begin
        if (accept) begin
          // Bits beyond CFG_W in the final slot fall off the end of the loop.
          for (int i = 0; i < CFG_W; i++) begin
            if (CNT_W'(i / CFG_WORD_W) == wcnt_q) begin
              shadow_d[i] = in_data[i % CFG_WORD_W];
            end
          end
          if (last_word) begin
            if ((in_data & PAD_MASK) != '0) begin
              err_d = 1'b1;
            end
            state_d = ARM;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end

      SKIP: begin
        if (accept) begin
          if (last_word) begin
            state_d = IDLE;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end

      ARM: begin
        if (cfg_apply) begin
          tile_cfg_d   = shadow_q;
          cfg_loaded_d = 1'b1;
          state_d      = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wcnt_q       <= '0;
      shadow_q     <= '0;
      tile_cfg_q   <= '0;
      cfg_loaded_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      shadow_q     <= shadow_d;
      tile_cfg_q   <= tile_cfg_d;
      cfg_loaded_q <= cfg_loaded_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_dice_tile_cfg_loader.sv
// Self-checking bench for dice_tile_cfg_loader: directed scenarios followed
// by random word streams, all compared against a packet-level reference model.
module tb_dice_tile_cfg_loader;

  localparam int TID = 3;
  localparam int IDW = 8;
  localparam int CW  = 156;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [31:0]   in_data;
  logic          in_ready;
  logic          cfg_apply;
  logic [CW-1:0] tile_cfg;
  logic          cfg_loaded;
  logic          busy;
  logic          err;

  always #5 clk = ~clk;

  dice_tile_cfg_loader #(
    .TILE_ID(TID),
    .ID_W   (IDW),
    .CFG_W  (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .cfg_apply (cfg_apply),
    .tile_cfg  (tile_cfg),
    .cfg_loaded(cfg_loaded),
    .busy      (busy),
    .err       (err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk_eq(input string tag, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference model: tracks whole packets as queues of words.
  bit          m_armed, m_in_pkt, m_mine, m_loaded, m_err;
  logic [31:0] m_pkt[$];
  logic [31:0] m_shadow[5];
  logic [CW-1:0] m_cfg;

  function automatic logic [CW-1:0] pack_words();
    logic [159:0] t;
    for (int k = 0; k < 5; k++) t[32*k +: 32] = m_shadow[k];
    return t[CW-1:0];
  endfunction

  task automatic model_reset();
    m_armed = 0; m_in_pkt = 0; m_mine = 0; m_loaded = 0; m_err = 0;
    m_pkt.delete();
    for (int k = 0; k < 5; k++) m_shadow[k] = '0;
    m_cfg = '0;
  endtask

  task automatic model_step(input logic v, input logic [31:0] d, input logic a, input logic r);
    if (r) begin
      model_reset();
    end else if (m_armed) begin
      if (a) begin
        m_cfg    = pack_words();
        m_loaded = 1;
        m_armed  = 0;
      end
    end else if (v) begin
      if (!m_in_pkt) begin
        if (d[31:24] != 8'hC5) begin
          m_err = 1;
        end else begin
          m_in_pkt = 1;
          m_mine   = (d[IDW-1:0] == IDW'(TID));
          m_pkt.delete();
        end
      end else begin
        m_pkt.push_back(d);
        if (m_pkt.size() == 5) begin
          m_in_pkt = 0;
          if (m_mine) begin
            if (d[31:28] != 4'h0) m_err = 1;
            for (int k = 0; k < 5; k++) m_shadow[k] = m_pkt[k];
            m_armed = 1;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    chk_eq("in_ready",   CW'(in_ready),   CW'(!m_armed));
    chk_eq("busy",       CW'(busy),       CW'(m_in_pkt || m_armed));
    chk_eq("cfg_loaded", CW'(cfg_loaded), CW'(m_loaded));
    chk_eq("err",        CW'(err),        CW'(m_err));
    chk_eq("tile_cfg",   tile_cfg,        m_cfg);
  endtask

  task automatic cycle(input logic v, input logic [31:0] d, input logic a, input logic r);
    in_valid  = v;
    in_data   = d;
    cfg_apply = a;
    rst       = r;
    check_all();
    model_step(v, d, a, r);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    cycle(1'b1, w, 1'b0, 1'b0);
  endtask

  task automatic apply_pulse();
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  logic [CW-1:0] basic_exp;
  logic [CW-1:0] prev_cfg;
  logic [27:0]   top_bits;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; cfg_apply = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk_eq("rst_tile_cfg", tile_cfg, '0);
    chk_eq("rst_loaded",   CW'(cfg_loaded), '0);
    chk_eq("rst_err",      CW'(err), '0);
    chk_eq("rst_busy",     CW'(busy), '0);
    chk_eq("rst_ready",    CW'(in_ready), CW'(1));

    // Foreign packet: skipped, apply ignored
    send(32'hC500_0007);
    for (int k = 0; k < 5; k++) begin
      chk_eq("skip_ready", CW'(in_ready), CW'(1));
      send($urandom);
      if (k == 3) chk_eq("skip_busy_mid", CW'(busy), CW'(1));
    end
    chk_eq("skip_busy_end", CW'(busy), '0);
    apply_pulse();
    chk_eq("skip_cfg", tile_cfg, '0);

    // Basic load with a gap mid-packet
    basic_exp = {28'hAAA_AAAA, 32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    send(32'hC500_0003);
    send(32'h1111_1111);
    send(32'h2222_2222);
    cycle(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    send(32'h3333_3333);
    send(32'h4444_4444);
    send(32'h0AAA_AAAA);
    chk_eq("arm_ready", CW'(in_ready), '0);
    chk_eq("arm_busy",  CW'(busy), CW'(1));
    chk_eq("arm_cfg_not_yet", tile_cfg, '0);
    apply_pulse();
    chk_eq("basic_cfg",    tile_cfg, basic_exp);
    chk_eq("basic_loaded", CW'(cfg_loaded), CW'(1));
    chk_eq("basic_err",    CW'(err), '0);
    chk_eq("basic_idle",   CW'(busy), '0);

    // Last payload word together with apply: arms only, second apply commits
    prev_cfg = tile_cfg;
    send(32'hC5AB_CD03);
    for (int k = 0; k < 4; k++) send(32'h5000_0000 + k);
    cycle(1'b1, 32'h0123_4567, 1'b1, 1'b0);
    chk_eq("simul_cfg_held", tile_cfg, prev_cfg);
    chk_eq("simul_armed",    CW'(in_ready), '0);
    apply_pulse();
    chk_eq("simul_cfg", tile_cfg,
           {28'h123_4567, 32'h5000_0003, 32'h5000_0002, 32'h5000_0001, 32'h5000_0000});

    // Backpressure in ARM, multi-cycle apply commits once
    send(32'hC500_0003);
    for (int k = 0; k < 5; k++) send(32'h0600_0000 + k);
    for (int k = 0; k < 4; k++) begin
      chk_eq("bp_ready", CW'(in_ready), '0);
      cycle(1'b1, 32'hC500_0003, 1'b0, 1'b0);
    end
    cycle(1'b1, 32'hC500_0003, 1'b1, 1'b0);
    chk_eq("bp_cfg", tile_cfg,
           {28'h600_0004, 32'h0600_0003, 32'h0600_0002, 32'h0600_0001, 32'h0600_0000});
    chk_eq("bp_ready_after", CW'(in_ready), CW'(1));
    cycle(1'b1, 32'hC500_0003, 1'b1, 1'b0);
    chk_eq("bp_hdr_taken", CW'(busy), CW'(1));
    for (int k = 0; k < 5; k++) send(32'h0700_0000 + k);
    apply_pulse();

    // Bad magic header
    send(32'h1200_0003);
    chk_eq("badhdr_err",  CW'(err), CW'(1));
    chk_eq("badhdr_idle", CW'(busy), '0);

    // Nonzero pad bits: word still loaded, error flagged
    send(32'hC500_0003);
    for (int k = 0; k < 4; k++) send(32'h0800_0000 + k);
    send(32'hF000_0001);
    apply_pulse();
    top_bits = tile_cfg[155:128];
    chk_eq("pad_top", CW'(top_bits), CW'(28'h1));
    chk_eq("pad_err", CW'(err), CW'(1));

    // Reset mid-load, then a clean packet
    send(32'hC500_0003);
    send(32'h9999_9999);
    send(32'h8888_8888);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    chk_eq("mid_rst_cfg",    tile_cfg, '0);
    chk_eq("mid_rst_loaded", CW'(cfg_loaded), '0);
    chk_eq("mid_rst_err",    CW'(err), '0);
    chk_eq("mid_rst_busy",   CW'(busy), '0);
    send(32'hC500_0003);
    send(32'hA1A1_A1A1);
    send(32'hB2B2_B2B2);
    send(32'hC3C3_C3C3);
    send(32'hD4D4_D4D4);
    send(32'h0E5E_5E5E);
    apply_pulse();
    chk_eq("mid_rst_reload", tile_cfg,
           {28'hE5E_5E5E, 32'hD4D4_D4D4, 32'hC3C3_C3C3, 32'hB2B2_B2B2, 32'hA1A1_A1A1});

    // Random streams
    for (int n = 0; n < 4000; n++) begin
      logic [31:0] w;
      logic v, a, r;
      v = ($urandom_range(0, 9) < 7);
      a = ($urandom_range(0, 9) < 2);
      r = ($urandom_range(0, 299) == 0);
      w = $urandom;
      if (!m_in_pkt) begin
        case ($urandom_range(0, 9))
          0: if (w[31:24] == 8'hC5) w[31:24] = 8'h00;
          1, 2, 3: begin w[31:24] = 8'hC5; w[7:0] = 8'($urandom_range(4, 255)); end
          default: begin w[31:24] = 8'hC5; w[7:0] = 8'(TID); end
        endcase
      end else if (m_pkt.size() == 4 && $urandom_range(0, 3) != 0) begin
        w[31:28] = 4'h0;
      end
      cycle(v, w, a, r);
    end
    check_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
